// File: rtl/spi_host_sequencer.sv
// SPI host sequencer (mode 0). It accepts one register command over a
// valid/ready handshake and runs one fixed-length frame on sclk/csn/mosi. For
// reads it captures 16 MISO bits. A one-cycle response pulse carries the read
// data.
//
// Ports:
//   clk_i, rst_ni        system clock, async active-low reset
//   cmd_valid_i/ready_o  command handshake; cmd_rw_i (1=write), cmd_addr_i,
//                        cmd_wdata_i are latched on handshake
//   abort_i              kill the frame in progress (SHIFT/HOLD only)
//   rsp_valid_o          one-cycle pulse when a frame completes normally
//   rsp_rdata_o          read data (0 after a write), held between pulses
//   busy_o               not IDLE
//   sclk_o, csn_o,
//   mosi_o, miso_i       SPI pins
//
// All pin and response outputs come from registers that are fed by the
// current state. They therefore trail the state register by one cycle:
// csn falls the cycle after the handshake edge, and rsp_valid rises one cycle
// after GAP is entered.
module spi_host_sequencer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 34,
  parameter int unsigned WR_START   = 15,
  parameter int unsigned RD_START   = 14
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_rw_i,
  input  logic [7:0]  cmd_addr_i,
  input  logic [15:0] cmd_wdata_i,
  input  logic        abort_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        csn_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int unsigned PH_W = $clog2(2*CLK_DIV);
  localparam int unsigned SL_W = $clog2(FRAME_BITS);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(2*CLK_DIV-1);
  localparam logic [PH_W-1:0] PH_HIGH   = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'(CLK_DIV-1);
  localparam logic [SL_W-1:0] SL_LAST   = SL_W'(FRAME_BITS-1);
  localparam logic [SL_W-1:0] RD_FIRST  = SL_W'(RD_START);
  localparam logic [SL_W-1:0] RD_LAST   = SL_W'(RD_START+15);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_e;

  state_e                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;   // slot phase in SHIFT, cycle count in HOLD/GAP
  logic [SL_W-1:0]       slot_q, slot_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;   // MOSI pattern, bit k = slot k
  logic                  rw_q, rw_d;
  logic                  abrt_q, abrt_d;     // current GAP was entered by abort
  logic [15:0]           sh_q, sh_d;
  logic                  csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [15:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  take, abort_take, in_frame;

  assign in_frame   = (state_q == SHIFT) || (state_q == HOLD);
  assign take       = cmd_valid_i && (state_q == IDLE);
  assign abort_take = abort_i && in_frame;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SHIFT;
      SHIFT:   if (abort_i) state_d = GAP;
               else if (phase_q == PH_LAST && slot_q == SL_LAST) state_d = HOLD;
      HOLD:    if (abort_i || phase_q == HOLD_LAST) state_d = GAP;
      GAP:     if (phase_q == PH_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Abort overrides the pins in the same edge that leaves the frame.
  always_comb begin
    csn_d       = !in_frame || abort_i;
    sclk_d      = (state_q == SHIFT) && (phase_q >= PH_HIGH) && !abort_i;
    mosi_d      = (state_q == SHIFT) && frame_q[slot_q] && !abort_i;
    rsp_valid_d = (state_q == GAP) && (phase_q == '0) && !abrt_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rsp_valid_d) rsp_rdata_d = rw_q ? 16'h0 : sh_q;
  end

  // Counters, command latch, MISO capture
  always_comb begin
    if (state_q == IDLE || state_d != state_q ||
        (state_q == SHIFT && phase_q == PH_LAST)) phase_d = '0;
    else                                          phase_d = phase_q + 1'b1;

    slot_d = slot_q;
    if (take) slot_d = '0;
    else if (state_q == SHIFT && phase_q == PH_LAST && slot_q != SL_LAST)
      slot_d = slot_q + 1'b1;   // saturates on the last slot

    rw_d    = rw_q;
    frame_d = frame_q;
    if (take) begin
      rw_d       = cmd_rw_i;
      frame_d    = '0;
      frame_d[0] = cmd_rw_i;
      for (int i = 0; i < 8; i++) frame_d[1+i] = cmd_addr_i[7-i];
      if (cmd_rw_i)
        for (int i = 0; i < 16; i++) frame_d[WR_START+i] = cmd_wdata_i[15-i];
    end

    abrt_d = abrt_q;
    if (take)            abrt_d = 1'b0;
    else if (abort_take) abrt_d = 1'b1;

    // MISO is stable while sclk is high; capture at the end of the high phase.
    sh_d = sh_q;
    if (take) sh_d = '0;
    else if (state_q == SHIFT && !rw_q && phase_q == PH_LAST &&
             slot_q >= RD_FIRST && slot_q <= RD_LAST)
      sh_d = {sh_q[14:0], miso_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q     <= '0;
      slot_q      <= '0;
      frame_q     <= '0;
      rw_q        <= 1'b0;
      abrt_q      <= 1'b0;
      sh_q        <= '0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      phase_q     <= phase_d;
      slot_q      <= slot_d;
      frame_q     <= frame_d;
      rw_q        <= rw_d;
      abrt_q      <= abrt_d;
      sh_q        <= sh_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign csn_o       = csn_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_spi_host_sequencer.sv
// Bench for spi_host_sequencer. It runs directed and randomized commands
// against a frame-level reference model and an SPI slave model.
module tb_spi_host_sequencer;
  localparam int CD  = 4;
  localparam int FB  = 34;
  localparam int WS  = 15;
  localparam int RS  = 14;
  localparam int LAT = 2*CD*FB + CD + 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0, abort = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0, rsp_rdata;
  logic rsp_valid, busy, sclk, csn, mosi, miso = 1'b0;

  int tests = 0, fails = 0, cyc = 0;
  logic [15:0] prev_rdata = '0;

  spi_host_sequencer #(.CLK_DIV(CD), .FRAME_BITS(FB), .WR_START(WS), .RD_START(RS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .abort_i(abort),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
    .sclk_o(sclk), .csn_o(csn), .mosi_o(mosi), .miso_i(miso));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI pin monitor and slave. sv holds the slave's MISO bit for each slot
  // (slot k at bit FB-1-k). obs collects MOSI at each sclk rise.
  logic [FB-1:0] sv = '0, obs = '0;
  int rcnt = 0, run = 0, hi_run = 0, last_gap = 0, glitch = 0, rsp_cnt = 0;
  logic p_csn = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_rsp = 1'b0;

  always @(negedge clk) begin
    if (csn) hi_run = p_csn ? hi_run + 1 : 1;
    if (!csn && p_csn) begin
      last_gap = hi_run; rcnt = 0; obs = '0; run = 1;
      miso = 1'(sv >> (FB-1));
    end else if (!csn && !p_csn) begin
      if (sclk != p_sclk) begin
        if (run != CD) glitch++;
        run = 1;
      end else run++;
      if (mosi != p_mosi && !(p_sclk && !sclk)) glitch++;
      if (sclk && !p_sclk) begin
        if (rcnt < FB) obs = obs | (FB'(mosi) << (FB-1-rcnt));
        rcnt++;
      end
      if (!sclk && p_sclk && rcnt < FB) miso = 1'(sv >> (FB-1-rcnt));
    end
    if (rsp_valid && !p_rsp) rsp_cnt++;
    p_csn = csn; p_sclk = sclk; p_mosi = mosi; p_rsp = rsp_valid;
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
    tests++;
    assert (obs_v === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs_v, exp_v);
    end
  endtask

  // Reference: MOSI per slot, slot k at bit FB-1-k.
  function automatic logic [FB-1:0] exp_frame(input logic rw, input logic [7:0] a, input logic [15:0] w);
    logic [FB-1:0] v;
    v = '0;
    v[FB-1] = rw;
    v[FB-2 -: 8] = a;
    if (rw) v[FB-1-WS -: 16] = w;
    return v;
  endfunction

  task automatic set_slave(input logic [15:0] rd);
    sv = FB'({$urandom(), $urandom()});
    sv[FB-1-RS -: 16] = rd;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("ready_timeout", 64'(0), 64'(1));
  endtask

  task automatic start(input logic rw, input logic [7:0] a, input logic [15:0] w,
                       input logic [15:0] rd, output int hs);
    bit ok;
    set_slave(rd);
    wait_ready(ok);
    cmd_rw = rw; cmd_addr = a; cmd_wdata = w; cmd_valid = 1'b1;
    hs = cyc + 1;
    tick();
    cmd_valid = 1'b0;
    cmd_rw = 1'($urandom()); cmd_addr = 8'($urandom()); cmd_wdata = 16'($urandom());
  endtask

  task automatic finish_cmd(input logic rw, input logic [7:0] a, input logic [15:0] w,
                            input logic [15:0] rd, input int hs, input string nm);
    int rc;
    logic [15:0] er;
    rc = -1;
    for (int i = 0; i < LAT + 40; i++) begin
      tick();
      if (rsp_valid) begin rc = cyc; break; end
    end
    if (rc < 0) chk({nm, "_timeout"}, 64'(0), 64'(1));
    else begin
      er = rw ? 16'h0 : rd;
      chk({nm, "_lat"},   64'(rc - hs), 64'(LAT));
      chk({nm, "_rdata"}, 64'(rsp_rdata), 64'(er));
      prev_rdata = er;
      tick();
      chk({nm, "_pulse"}, 64'(rsp_valid), 64'(0));
      chk({nm, "_edges"}, 64'(rcnt), 64'(FB));
      chk({nm, "_mosi"},  64'(obs), 64'(exp_frame(rw, a, w)));
      chk({nm, "_phase"}, 64'(glitch), 64'(0));
    end
  endtask

  initial begin
    int hs, hs2, r1, ab, rdy, n0;
    bit ok, saw;
    logic rw;
    logic [7:0] a;
    logic [15:0] w, rd;

    // Reset values
    tick(); tick();
    chk("rst_csn", 64'(csn), 64'(1));
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_rspv", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
    tick();

    // Directed write and read
    start(1'b1, 8'hA5, 16'hBEEF, 16'h0, hs);
    chk("wr_busy", 64'(busy), 64'(1));
    finish_cmd(1'b1, 8'hA5, 16'hBEEF, 16'h0, hs, "wr_a5");
    start(1'b0, 8'h3C, 16'hFFFF, 16'h1234, hs);
    finish_cmd(1'b0, 8'h3C, 16'hFFFF, 16'h1234, hs, "rd_3c");

    // Randomized commands
    for (int n = 0; n < 4; n++) begin
      rw = 1'($urandom_range(1, 0)); a = 8'($urandom()); w = 16'($urandom()); rd = 16'($urandom());
      start(rw, a, w, rd, hs);
      finish_cmd(rw, a, w, rd, hs, rw ? "rnd_wr" : "rnd_rd");
    end

    // Back-to-back with cmd_valid held: write, then read
    a = 8'($urandom()); w = 16'($urandom()); rd = 16'($urandom());
    set_slave(rd);
    wait_ready(ok);
    cmd_rw = 1'b1; cmd_addr = 8'h11; cmd_wdata = w; cmd_valid = 1'b1;
    hs = cyc + 1;
    tick();
    cmd_rw = 1'b0; cmd_addr = a; cmd_wdata = 16'($urandom());
    r1 = -1; hs2 = -1;
    for (int i = 0; i < LAT + 60; i++) begin
      if (rsp_valid && r1 < 0) begin
        r1 = cyc;
        chk("b2b_wr_lat", 64'(r1 - hs), 64'(LAT));
        chk("b2b_wr_rdata", 64'(rsp_rdata), 64'(0));
        chk("b2b_wr_mosi", 64'(obs), 64'(exp_frame(1'b1, 8'h11, w)));
      end
      if (cmd_ready && r1 >= 0) begin hs2 = cyc + 1; break; end
      tick();
    end
    tick();
    cmd_valid = 1'b0;
    if (hs2 < 0) chk("b2b_timeout", 64'(0), 64'(1));
    else begin
      chk("b2b_spacing", 64'(hs2 - r1), 64'(8));
      finish_cmd(1'b0, a, 16'h0, rd, hs2, "b2b_rd");
      chk("b2b_gap_ge8", 64'(last_gap >= 8), 64'(1));
    end

    // Abort during the high phase of slot 10 of a read
    start(1'b0, 8'h5A, 16'h0, 16'hC0DE, hs);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rcnt == 11 && sclk) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("abort_slot_timeout", 64'(0), 64'(1));
    n0 = rsp_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ab = cyc;
    chk("abort_csn", 64'(csn), 64'(1));
    chk("abort_sclk", 64'(sclk), 64'(0));
    chk("abort_mosi", 64'(mosi), 64'(0));
    rdy = -1; saw = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready && rdy < 0) rdy = cyc;
      if (rsp_valid) saw = 1'b1;
      tick();
    end
    chk("abort_ready_cyc", 64'(rdy - ab), 64'(8));
    chk("abort_no_rsp", 64'(saw || rsp_cnt != n0), 64'(0));
    chk("abort_rdata_kept", 64'(rsp_rdata), 64'(prev_rdata));

    // Reset in slot 20, then a normal write
    w = 16'($urandom());
    start(1'b1, 8'h77, w, 16'h0, hs);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (rcnt == 21 && sclk) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("rst_slot_timeout", 64'(0), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_csn", 64'(csn), 64'(1));
    chk("midrst_sclk", 64'(sclk), 64'(0));
    chk("midrst_mosi", 64'(mosi), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_rdata", 64'(rsp_rdata), 64'(0));
    prev_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    a = 8'($urandom()); w = 16'($urandom());
    start(1'b1, a, w, 16'h0, hs);
    finish_cmd(1'b1, a, w, 16'h0, hs, "post_rst_wr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
